// File: rtl/led_ctrl_pkg.sv
// Shared types and field positions for the LED pattern controller.
// The low switch pair selects the display mode and the next pair selects the speed.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int MODE_LSB = 0;
    localparam int SPD_LSB  = 2;

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchroniser followed by a debouncer that accepts a new level
// only after it has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter holds how many mismatching cycles have been seen so far; any agreement restarts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            o_db  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
            if (sync2 == o_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                o_db <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_controller.sv
// Board-level LED driver: debounced switches choose between mirroring the switches
// and one of three prescaler-timed LED patterns at one of four speeds.
module led_pattern_controller #(
    parameter int N               = 4,
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_switch,
    output logic [N-1:0] o_led,
    output logic [1:0]   o_mode
);

    import led_ctrl_pkg::*;

    localparam int           TW           = $clog2(TICK_DIV * 8 + 1);
    localparam logic [N-1:0] ONE_HOT_INIT = N'(1);
    localparam logic [N-1:0] ALL_ON       = '1;

    logic [N-1:0]  sw_db;
    mode_e         mode;
    mode_e         mode_q;
    logic [1:0]    spd;
    logic [1:0]    spd_q;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_d;
    logic [TW-1:0] tick_term;
    logic          tick;
    logic          mode_chg;
    logic          spd_chg;
    logic [N-1:0]  pattern;
    logic [N-1:0]  pattern_d;
    logic [N-1:0]  led_d;
    dir_e          dir;
    dir_e          dir_d;

    for (genvar i = 0; i < N; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_raw  (i_switch[i]),
            .o_db   (sw_db[i])
        );
    end

    assign mode   = mode_e'(sw_db[MODE_LSB +: 2]);
    assign spd    = sw_db[SPD_LSB +: 2];
    assign o_mode = mode_q;

    // A mode change reloads the pattern and restarts the period; a speed-only change just restarts
    // the period. Either suppresses the step that a coincident tick would otherwise take.
    always_comb begin
        mode_chg   = (mode != mode_q);
        spd_chg    = (spd != spd_q);
        tick_term  = (TW'(TICK_DIV) << spd) - TW'(1);
        tick       = (tick_cnt == tick_term);
        tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
        pattern_d  = pattern;
        dir_d      = dir;

        if (mode_chg || spd_chg) begin
            tick_cnt_d = '0;
        end

        if (mode_chg) begin
            dir_d     = DIR_UP;
            pattern_d = (mode == MODE_BLINK) ? ALL_ON : ONE_HOT_INIT;
        end else if (tick && !spd_chg) begin
            case (mode)
                MODE_SHIFT: pattern_d = {pattern[N-2:0], pattern[N-1]};
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        pattern_d = pattern << 1;
                        if (pattern_d[N-1]) dir_d = DIR_DOWN;
                    end else begin
                        pattern_d = pattern >> 1;
                        if (pattern_d[0]) dir_d = DIR_UP;
                    end
                end
                MODE_BLINK: pattern_d = ~pattern;
                default: pattern_d = pattern;
            endcase
        end

        led_d = (mode == MODE_PASS) ? sw_db : pattern_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
            pattern  <= '0;
            dir      <= DIR_UP;
            mode_q   <= MODE_PASS;
            spd_q    <= 2'd0;
            o_led    <= '0;
        end else begin
            tick_cnt <= tick_cnt_d;
            pattern  <= pattern_d;
            dir      <= dir_d;
            mode_q   <= mode;
            spd_q    <= spd;
            o_led    <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_controller.sv
// Bench for led_pattern_controller: scripted board scenarios with literal expectations,
// then random switch activity checked every cycle against a behavioural model.
module tb_led_pattern_controller;

    localparam int N               = 4;
    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 3;

    logic         i_clk    = 1'b0;
    logic         i_rst_n  = 1'b0;
    logic [N-1:0] i_switch = '0;
    logic [N-1:0] o_led;
    logic [1:0]   o_mode;

    int checks   = 0;
    int failures = 0;

    led_pattern_controller #(
        .N              (N),
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_switch(i_switch),
        .o_led   (o_led),
        .o_mode  (o_mode)
    );

    always #5 i_clk = ~i_clk;

    bit           model_valid = 0;
    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic [N-1:0] m_db;
    logic [N-1:0] m_hist[$];
    int           m_mode_prev;
    int           m_spd_prev;
    int           m_phase;
    int           m_steps;
    logic [N-1:0] exp_led;
    logic [1:0]   exp_mode;

    // Pattern shown after k steps in a given mode, from the mode's closed-form definition.
    function automatic logic [N-1:0] pattern_for(input int mode, input int k);
        logic [N-1:0] v;
        int p;
        int pos;
        v = '0;
        case (mode)
            1: v[k % N] = 1'b1;
            2: begin
                p   = k % (2 * N - 2);
                pos = (p < N) ? p : (2 * N - 2 - p);
                v[pos] = 1'b1;
            end
            3: v = ((k % 2) == 0) ? '1 : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Model: inputs seen two edges late; a debounced bit flips once the last DEBOUNCE_CYCLES
    // synchronised samples all disagree with it; patterns advance once per full period.
    always @(posedge i_clk) begin
        logic [N-1:0] db_next;
        int mode;
        int spd;
        bit all_diff;
        if (!i_rst_n) begin
            model_valid = 1;
            m_s1        = '0;
            m_s2        = '0;
            m_db        = '0;
            m_hist.delete();
            m_mode_prev = 0;
            m_spd_prev  = 0;
            m_phase     = 0;
            m_steps     = 0;
            exp_led     = '0;
            exp_mode    = 2'd0;
        end else if (model_valid) begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > DEBOUNCE_CYCLES) void'(m_hist.pop_front());
            db_next = m_db;
            if (m_hist.size() == DEBOUNCE_CYCLES) begin
                for (int b = 0; b < N; b++) begin
                    all_diff = 1;
                    foreach (m_hist[j]) if (m_hist[j][b] == m_db[b]) all_diff = 0;
                    if (all_diff) db_next[b] = ~m_db[b];
                end
            end
            mode = int'(m_db[1:0]);
            spd  = int'(m_db[3:2]);
            if (mode != m_mode_prev || spd != m_spd_prev) begin
                m_phase = 0;
                if (mode != m_mode_prev) m_steps = 0;
            end else begin
                m_phase++;
                if (m_phase == (TICK_DIV << spd)) begin
                    m_phase = 0;
                    m_steps++;
                end
            end
            exp_led     = (mode == 0) ? m_db : pattern_for(mode, m_steps);
            exp_mode    = 2'(mode);
            m_mode_prev = mode;
            m_spd_prev  = spd;
            m_db        = db_next;
            m_s2        = m_s1;
            m_s1        = i_switch;
        end
    end

    always @(negedge i_clk) begin
        if (model_valid) begin
            checks++;
            if (o_led !== exp_led) begin
                failures++;
                $display("[TB] FAIL model_led at %0t: o_led=%b expected=%b", $time, o_led, exp_led);
            end
            checks++;
            if (o_mode !== exp_mode) begin
                failures++;
                $display("[TB] FAIL model_mode at %0t: o_mode=%0d expected=%0d", $time, o_mode, exp_mode);
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] sw);
        i_switch = sw;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] led, input logic [1:0] mode);
        checks++;
        if (o_led !== led || o_mode !== mode) begin
            failures++;
            $display("[TB] FAIL %s at %0t: o_led=%b o_mode=%0d expected o_led=%b o_mode=%0d",
                     name, $time, o_led, o_mode, led, mode);
        end
    endtask

    initial begin
        logic [N-1:0] shift_seq[4];
        logic [N-1:0] bounce_seq[6];
        shift_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

        i_rst_n = 1'b0;
        applyStimulus(4'b1111);
        waitEdges(1);
        checkOutput("reset_edge1", 4'b0000, 2'd0);
        waitEdges(1);
        checkOutput("reset_edge2", 4'b0000, 2'd0);

        i_rst_n = 1'b1;
        applyStimulus(4'b0100);
        for (int t = 1; t <= 5; t++) begin
            waitEdges(1);
            checkOutput("pass_before_latency", 4'b0000, 2'd0);
        end
        waitEdges(1);
        checkOutput("pass_t6", 4'b0100, 2'd0);

        applyStimulus(4'b0101);
        for (int i = 0; i < 20; i++) begin
            waitEdges(1);
            if (i == 1) applyStimulus(4'b0100);
            checkOutput("glitch_rejected", 4'b0100, 2'd0);
        end

        applyStimulus(4'b0001);
        waitEdges(6);
        checkOutput("shift_init", 4'b0001, 2'd1);
        for (int i = 0; i < 4; i++) begin
            waitEdges(4);
            checkOutput("shift_step", shift_seq[i], 2'd1);
        end

        applyStimulus(4'b0110);
        waitEdges(6);
        checkOutput("bounce_init", 4'b0001, 2'd2);
        for (int i = 0; i < 6; i++) begin
            waitEdges(8);
            checkOutput("bounce_step", bounce_seq[i], 2'd2);
        end

        applyStimulus(4'b0011);
        waitEdges(6);
        checkOutput("blink_init", 4'b1111, 2'd3);
        waitEdges(4);
        checkOutput("blink_off", 4'b0000, 2'd3);
        waitEdges(4);
        checkOutput("blink_on", 4'b1111, 2'd3);
        waitEdges(2);
        i_rst_n = 1'b0;
        waitEdges(1);
        checkOutput("mid_pattern_reset", 4'b0000, 2'd0);
        i_rst_n = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            waitEdges(1);
            checkOutput("post_reset_pass", 4'b0000, 2'd0);
        end

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                i_rst_n = 1'b0;
                waitEdges(int'($urandom_range(1, 2)));
                i_rst_n = 1'b1;
            end else begin
                applyStimulus(N'($urandom_range(0, 15)));
                waitEdges(int'($urandom_range(1, 40)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
